dcache: RTL and testbench
=========================

# dcache

Direct-mapped, write-through, no-write-allocate data cache between the EX_MEM pipeline register and a multi-cycle external data memory, replacing the single-cycle Data_Memory in the MEM stage. It serves hits in the same cycle, stalls the pipeline on read misses and all writes, and runs a req/ack handshake to memory. Saturating hit/miss counters support performance measurement.

## Interface
- INDEX_W, 4, index bits; LINES = 2**INDEX_W one-word lines
- CNT_W, 16, width of hit/miss counters
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-low
- memread_i  in  1  load request from EX_MEM
- memwrite_i  in  1  store request from EX_MEM
- memaddr_i  in  32  byte address; bits [1:0] ignored
- writedata_i  in  32  store data
- memdata_o  out  32  load data to MEM_WB
- stall_o  out  1  freezes PC, IF_ID, ID_EX, EX_MEM; MEM_WB loads a bubble
- mem_req_o  out  1  external request, held until ack
- mem_we_o  out  1  1 = write, 0 = read; valid with mem_req_o
- mem_addr_o  out  32  word-aligned address ({memaddr_i[31:2],2'b00})
- mem_wdata_o  out  32  write data
- mem_rdata_i  in  32  read data, valid with mem_ack_i
- mem_ack_i  in  1  one-cycle completion strobe
- hit_cnt_o  out  CNT_W  read-hit count, saturating
- miss_cnt_o  out  CNT_W  read-miss count, saturating

## Operation
- Address split: index = memaddr_i[INDEX_W+1:2], tag = memaddr_i[31:INDEX_W+2]; hit = valid[index] && tag match.
- FSM states: IDLE, FILL, WRITE.
- IDLE, memwrite_i: capture addr/data and go to WRITE. memwrite_i has priority if memread_i is also asserted; this case is illegal but defined.
- IDLE, memread_i and hit: memdata_o = line data; no stall; hit_cnt += 1.
- IDLE, memread_i and miss: capture addr and go to FILL; miss_cnt += 1.
- IDLE, no request: memdata_o = 0.
- FILL: mem_req_o=1, mem_we_o=0. On mem_ack_i: write line (valid=1, tag, mem_rdata_i), drive memdata_o = mem_rdata_i the same cycle, then go to IDLE.
- WRITE: mem_req_o=1, mem_we_o=1, mem_wdata_o = captured data. On mem_ack_i go to IDLE. If the captured address hits, update line data at entry to WRITE. A write miss leaves the array untouched.
- stall_o = (IDLE && (memwrite_i || (memread_i && !hit))) || (!IDLE && !mem_ack_i).
- Counters saturate at all-ones and never wrap. Writes are not counted.
- mem_ack_i in IDLE is ignored.
- mem_addr_o and mem_wdata_o stay stable while mem_req_o=1.

## Timing
- Reset (asynchronous, rst_i=0):
  - state = IDLE; all valid bits = 0; counters = 0.
  - mem_req_o = 0, mem_we_o = 0, mem_addr_o = 0, mem_wdata_o = 0.
  - stall_o = 0 and memdata_o = 0 while no request is present.
- Reset mid-FILL or mid-WRITE aborts the transfer. mem_req_o drops immediately and a later ack is ignored.
- Read hit: 0-cycle latency (combinational read).
- Read miss: stall asserted in the request cycle. mem_req_o rises the next cycle. Data returns and stall falls in the ack cycle, so the pipeline advances on that edge. Total stall = 1 + N cycles, where ack arrives N cycles after req rises.
- Write: same stall profile as a read miss.
- Back-to-back: a request following a completed transfer is evaluated in IDLE the cycle after ack. There is no dead cycle beyond that.
- Array writes occur on the clock edge. A fill is visible as a hit on the next cycle.

## Structure
- Package dcache_pkg:
  - state enum (IDLE, FILL, WRITE)
  - localparams: default INDEX_W, TAG_W = 30-INDEX_W
  - tag/index extraction functions
- Sub-module dcache_array: valid/tag/data storage.
  - asynchronous read, synchronous write, active-low asynchronous clear of valid bits
- dcache holds the FSM, capture registers, stall logic, and counters.

## Test plan
- Reset, then read 0x40 with ack 3 cycles after req → stall_o high 4 cycles; memdata_o = mem_rdata_i (0xDEADBEEF) in the ack cycle; miss_cnt=1. Read 0x40 again → no stall, 0xDEADBEEF, hit_cnt=1.
- Write 0x40 ← 0x12345678 after the fill → mem_we_o=1, stall until ack, line updated. Read 0x40 → hit, 0x12345678.
- Write 0x80 (miss), then read 0x80 → write leaves the array unchanged; the read misses (miss_cnt increments).
- Conflict: fill 0x04, then read 0x44 (same index, INDEX_W=4) → miss, line replaced. Read 0x04 → miss again.
- Assert rst_i=0 mid-FILL → mem_req_o drops at once, state IDLE, valid cleared. A late ack causes no array write.
- Preload miss_cnt near saturation (CNT_W=4, 16 misses) → counter holds at 15.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and address-split helpers for the direct-mapped write-through data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } state_e;

  localparam int unsigned INDEX_W_DEF = 4;
  localparam int unsigned TAG_W_DEF   = 30 - INDEX_W_DEF;

  // Callers cast the 32-bit result down to their own index/tag width.
  function automatic logic [31:0] addr_index(input logic [31:0] addr, input int unsigned iw);
    return (addr >> 2) & ((32'd1 << iw) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int unsigned iw);
    return addr >> (iw + 2);
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage: one-word lines, asynchronous read, synchronous write.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int unsigned INDEX_W = INDEX_W_DEF,
  parameter int unsigned TAG_W   = 30 - INDEX_W
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [INDEX_W-1:0] rd_idx_i,
  output logic               rd_valid_o,
  output logic [TAG_W-1:0]   rd_tag_o,
  output logic [31:0]        rd_data_o,
  input  logic               we_i,
  input  logic [INDEX_W-1:0] wr_idx_i,
  input  logic [TAG_W-1:0]   wr_tag_i,
  input  logic [31:0]        wr_data_i
);

  localparam int unsigned LINES = 2 ** INDEX_W;

  logic [LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  always_comb begin
    valid_d = valid_q;
    if (we_i) valid_d[wr_idx_i] = 1'b1;
  end

  // Only valid bits are cleared; tag/data contents are don't-care while invalid.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache with req/ack memory port.
module dcache
  import dcache_pkg::*;
#(
  parameter int unsigned INDEX_W = INDEX_W_DEF,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             memread_i,
  input  logic             memwrite_i,
  input  logic [31:0]      memaddr_i,
  input  logic [31:0]      writedata_i,
  output logic [31:0]      memdata_o,
  output logic             stall_o,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [31:0]      mem_addr_o,
  output logic [31:0]      mem_wdata_o,
  input  logic [31:0]      mem_rdata_i,
  input  logic             mem_ack_i,
  output logic [CNT_W-1:0] hit_cnt_o,
  output logic [CNT_W-1:0] miss_cnt_o
);

  localparam int unsigned TAG_W = 30 - INDEX_W;

  state_e           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

  logic [31:0]        word_addr;
  logic [INDEX_W-1:0] req_idx;
  logic [TAG_W-1:0]   req_tag;
  logic               line_valid;
  logic [TAG_W-1:0]   line_tag;
  logic [31:0]        line_data;
  logic               hit;
  logic               arr_we;
  logic [INDEX_W-1:0] arr_idx;
  logic [TAG_W-1:0]   arr_tag;
  logic [31:0]        arr_data;

  assign word_addr = {memaddr_i[31:2], 2'b00};
  assign req_idx   = INDEX_W'(addr_index(memaddr_i, INDEX_W));
  assign req_tag   = TAG_W'(addr_tag(memaddr_i, INDEX_W));
  assign hit       = line_valid && (line_tag == req_tag);

  dcache_array #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W)
  ) u_array (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rd_idx_i   (req_idx),
    .rd_valid_o (line_valid),
    .rd_tag_o   (line_tag),
    .rd_data_o  (line_data),
    .we_i       (arr_we),
    .wr_idx_i   (arr_idx),
    .wr_tag_i   (arr_tag),
    .wr_data_i  (arr_data)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    arr_we     = 1'b0;
    arr_idx    = req_idx;
    arr_tag    = req_tag;
    arr_data   = writedata_i;
    memdata_o  = '0;
    stall_o    = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Stores win over loads; a store hit refreshes the line as the write starts.
        if (memwrite_i) begin
          state_d = WRITE;
          addr_d  = word_addr;
          wdata_d = writedata_i;
          stall_o = 1'b1;
          arr_we  = hit;
        end else if (memread_i) begin
          if (hit) begin
            memdata_o = line_data;
            if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_W'(1);
          end else begin
            state_d = FILL;
            addr_d  = word_addr;
            stall_o = 1'b1;
            if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_W'(1);
          end
        end
      end
      FILL: begin
        stall_o = !mem_ack_i;
        if (mem_ack_i) begin
          arr_we    = 1'b1;
          arr_idx   = INDEX_W'(addr_index(addr_q, INDEX_W));
          arr_tag   = TAG_W'(addr_tag(addr_q, INDEX_W));
          arr_data  = mem_rdata_i;
          memdata_o = mem_rdata_i;
          state_d   = IDLE;
        end
      end
      WRITE: begin
        stall_o = !mem_ack_i;
        if (mem_ack_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    req_d = (state_d != IDLE);
    we_d  = (state_d == WRITE);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      req_q      <= req_d;
      we_q       <= we_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign hit_cnt_o   = hit_cnt_q;
  assign miss_cnt_o  = miss_cnt_q;

endmodule

// File: tb/tb_dcache.sv
// Directed bench for dcache: misses, hits, writes, conflicts, reset abort, counter saturation.
module tb_dcache;

  localparam int unsigned CNT_W = 4;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b0;
  logic             memread_i = 1'b0;
  logic             memwrite_i = 1'b0;
  logic [31:0]      memaddr_i = '0;
  logic [31:0]      writedata_i = '0;
  logic [31:0]      memdata_o;
  logic             stall_o;
  logic             mem_req_o;
  logic             mem_we_o;
  logic [31:0]      mem_addr_o;
  logic [31:0]      mem_wdata_o;
  logic [31:0]      mem_rdata_i = '0;
  logic             mem_ack_i = 1'b0;
  logic [CNT_W-1:0] hit_cnt_o;
  logic [CNT_W-1:0] miss_cnt_o;

  int n_vec = 0;
  int n_err = 0;

  dcache #(.INDEX_W(4), .CNT_W(CNT_W)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .memread_i   (memread_i),
    .memwrite_i  (memwrite_i),
    .memaddr_i   (memaddr_i),
    .writedata_i (writedata_i),
    .memdata_o   (memdata_o),
    .stall_o     (stall_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ack_i   (mem_ack_i),
    .hit_cnt_o   (hit_cnt_o),
    .miss_cnt_o  (miss_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Stalling transfer: ack arrives n cycles after mem_req_o rises, so n+1 stall cycles.
  task automatic xfer(input string nm, input logic we, input logic [31:0] addr,
                      input logic [31:0] wd, input int n, input logic [31:0] rd,
                      input logic [31:0] exp_addr);
    int stalls;
    @(negedge clk_i);
    memread_i   = !we;
    memwrite_i  = we;
    memaddr_i   = addr;
    writedata_i = wd;
    stalls      = 0;
    #1;
    if (stall_o) stalls++;
    @(posedge clk_i);
    for (int k = 1; k <= n + 1; k++) begin
      @(negedge clk_i);
      if (k == n + 1) begin
        mem_ack_i   = 1'b1;
        mem_rdata_i = rd;
      end
      #1;
      if (k == 1) begin
        chk({nm, "_req"}, 32'(mem_req_o), 32'd1);
        chk({nm, "_we"}, 32'(mem_we_o), 32'(we));
        chk({nm, "_addr"}, mem_addr_o, exp_addr);
        if (we) chk({nm, "_wdata"}, mem_wdata_o, wd);
      end
      if (stall_o) stalls++;
      if (k == n + 1 && !we) chk({nm, "_data"}, memdata_o, rd);
      @(posedge clk_i);
    end
    @(negedge clk_i);
    mem_ack_i  = 1'b0;
    memread_i  = 1'b0;
    memwrite_i = 1'b0;
    chk({nm, "_stalls"}, 32'(stalls), 32'(n + 1));
  endtask

  task automatic rd_hit(input string nm, input logic [31:0] addr, input logic [31:0] exp);
    @(negedge clk_i);
    memread_i = 1'b1;
    memaddr_i = addr;
    #1;
    chk({nm, "_stall"}, 32'(stall_o), 32'd0);
    chk({nm, "_data"}, memdata_o, exp);
    @(posedge clk_i);
    @(negedge clk_i);
    memread_i = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_req", 32'(mem_req_o), 32'd0);
    chk("rst_we", 32'(mem_we_o), 32'd0);
    chk("rst_addr", mem_addr_o, 32'd0);
    chk("rst_wdata", mem_wdata_o, 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_data", memdata_o, 32'd0);
    chk("rst_hits", 32'(hit_cnt_o), 32'd0);
    chk("rst_miss", 32'(miss_cnt_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;

    xfer("miss40", 1'b0, 32'h40, 32'h0, 3, 32'hDEADBEEF, 32'h40);
    chk("miss40_cnt", 32'(miss_cnt_o), 32'd1);
    rd_hit("hit40", 32'h40, 32'hDEADBEEF);
    chk("hit40_cnt", 32'(hit_cnt_o), 32'd1);

    xfer("wr40", 1'b1, 32'h40, 32'h12345678, 2, 32'h0, 32'h40);
    rd_hit("hit40b", 32'h40, 32'h12345678);
    chk("hit40b_cnt", 32'(hit_cnt_o), 32'd2);
    chk("wr40_miss_cnt", 32'(miss_cnt_o), 32'd1);

    // Store miss with unaligned low bits: memory sees the word address, array untouched.
    xfer("wr80", 1'b1, 32'h83, 32'hAAAA5555, 1, 32'h0, 32'h80);
    xfer("miss80", 1'b0, 32'h80, 32'h0, 2, 32'h0BADF00D, 32'h80);
    chk("miss80_cnt", 32'(miss_cnt_o), 32'd2);

    xfer("miss04", 1'b0, 32'h04, 32'h0, 1, 32'h11111111, 32'h04);
    rd_hit("hit04", 32'h04, 32'h11111111);
    chk("hit04_cnt", 32'(hit_cnt_o), 32'd3);
    xfer("miss44", 1'b0, 32'h44, 32'h0, 1, 32'h22222222, 32'h44);
    xfer("miss04b", 1'b0, 32'h04, 32'h0, 1, 32'h33333333, 32'h04);
    chk("conflict_cnt", 32'(miss_cnt_o), 32'd5);

    // Abort a fill with reset, then offer a stray ack while idle.
    @(negedge clk_i);
    memread_i = 1'b1;
    memaddr_i = 32'h40;
    @(posedge clk_i);
    @(negedge clk_i);
    #1;
    chk("abort_req_before", 32'(mem_req_o), 32'd1);
    memread_i = 1'b0;
    rst_i = 1'b0;
    #1;
    chk("abort_req", 32'(mem_req_o), 32'd0);
    chk("abort_stall", 32'(stall_o), 32'd0);
    chk("abort_addr", mem_addr_o, 32'd0);
    chk("abort_miss", 32'(miss_cnt_o), 32'd0);
    chk("abort_hits", 32'(hit_cnt_o), 32'd0);
    @(negedge clk_i);
    rst_i       = 1'b1;
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'hBAD0BAD0;
    #1;
    chk("late_ack_stall", 32'(stall_o), 32'd0);
    chk("late_ack_data", memdata_o, 32'd0);
    chk("late_ack_req", 32'(mem_req_o), 32'd0);
    @(negedge clk_i);
    mem_ack_i = 1'b0;
    #1;
    chk("late_ack_req2", 32'(mem_req_o), 32'd0);
    xfer("post_rst00", 1'b0, 32'h00, 32'h0, 1, 32'h55555555, 32'h00);
    xfer("post_rst04", 1'b0, 32'h04, 32'h0, 1, 32'h44444444, 32'h04);
    chk("post_rst_miss", 32'(miss_cnt_o), 32'd2);
    rd_hit("post_rst_hit", 32'h04, 32'h44444444);
    chk("post_rst_hits", 32'(hit_cnt_o), 32'd1);

    // Alternating tags on index 0 always miss; count must stick at 15.
    for (int i = 0; i < 16; i++) begin
      xfer("sat", 1'b0, (i % 2 == 1) ? 32'h140 : 32'h100, 32'h0, 1, 32'(i), (i % 2 == 1) ? 32'h140 : 32'h100);
      if (i == 12) chk("sat_reach", 32'(miss_cnt_o), 32'd15);
    end
    chk("sat_hold", 32'(miss_cnt_o), 32'd15);
    chk("sat_hits", 32'(hit_cnt_o), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
